// File: rtl/shift_row_col_serial.sv
// shift_row_col_serial
// Column-serial AES ShiftRows stage (32 bits per beat) with valid/ready on
// both sides. Four input columns fill one 128-bit bank. Once the bank is full
// it drains as four shifted columns. Two ping-pong banks let the next block
// be collected while the previous block drains. INVERSE=1 selects
// InvShiftRows for the decryption path.
module shift_row_col_serial #(
  parameter bit INVERSE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_col,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_col,
  output logic        out_last
);

  logic         wr_bank;
  logic [1:0]   wr_cnt;
  logic         rd_bank;
  logic [1:0]   rd_cnt;
  logic [1:0]   full;
  logic [127:0] bank [2];

  logic         in_fire;
  logic         out_fire;
  logic [1:0]   set_mask;
  logic [1:0]   clr_mask;

  // Builds output column c of SHIFT(s).
  // Row r takes its byte from source column (c+r)%4 in the forward direction
  // and from (c-r)%4 in the inverse direction.
  function automatic logic [31:0] shift_col(input logic [127:0] s,
                                            input logic [1:0]   c);
    logic [31:0] col;
    logic [1:0]  src;
    int          idx;
    col = '0;
    for (int r = 0; r < 4; r++) begin
      src = INVERSE ? (c - 2'(r)) : (c + 2'(r));
      idx = 4 * int'(src) + r;
      col[31-8*r -: 8] = s[127-8*idx -: 8];
    end
    return col;
  endfunction

  // Handshake decode and output datapath.
  // Reset holds both interfaces idle, and an empty output reads as zero.
  // NOTE: every signal driven here gets a default first, so no path through the block can infer a latch.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_col   = '0;
    out_last  = 1'b0;
    set_mask  = '0;
    clr_mask  = '0;
    if (rst_n) begin
      in_ready  = !full[wr_bank];
      out_valid = full[rd_bank];
    end
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (out_valid) begin
      out_col  = shift_col(bank[rd_bank], rd_cnt);
      out_last = (rd_cnt == 2'd3);
    end
    if (in_fire && wr_cnt == 2'd3) set_mask[wr_bank] = 1'b1;
    if (out_fire && rd_cnt == 2'd3) clr_mask[rd_bank] = 1'b1;
  end

  // Write and read pointers, plus the bank-full flags.
  // A set and a clear in the same cycle always target different banks.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_cnt  <= 2'd0;
      rd_bank <= 1'b0;
      rd_cnt  <= 2'd0;
      full    <= 2'b00;
    end else begin
      if (in_fire) begin
        wr_cnt <= wr_cnt + 2'd1;
        if (wr_cnt == 2'd3) wr_bank <= !wr_bank;
      end
      if (out_fire) begin
        rd_cnt <= rd_cnt + 2'd1;
        if (rd_cnt == 2'd3) rd_bank <= !rd_bank;
      end
      full <= (full | set_mask) & ~clr_mask;
    end
  end

  // Bank storage: each accepted column lands in its slot of the write bank.
  // NOTE: the banks carry no reset. The full flags gate all visibility, so stale data never reaches out_col.
  always_ff @(posedge clk) begin
    if (in_fire) bank[wr_bank][127-32*int'(wr_cnt) -: 32] <= in_col;
  end

endmodule

// File: tb/tb_shift_row_col_serial.sv
// Scoreboard bench for shift_row_col_serial.
// One forward instance runs the full directed and random sequence.
// A second instance with INVERSE=1 runs the inverse vector.
module tb_shift_row_col_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [31:0] in_col, out_col;
  logic        i_in_valid, i_in_ready, i_out_valid, i_out_ready, i_out_last;
  logic [31:0] i_in_col, i_out_col;

  typedef struct packed {
    logic        last;
    logic [31:0] col;
  } beat_t;

  beat_t q[$];
  beat_t iq[$];
  int    out_cyc[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    rand_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  shift_row_col_serial #(.INVERSE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
    .out_last(out_last)
  );

  shift_row_col_serial #(.INVERSE(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n),
    .in_valid(i_in_valid), .in_ready(i_in_ready), .in_col(i_in_col),
    .out_valid(i_out_valid), .out_ready(i_out_ready), .out_col(i_out_col),
    .out_last(i_out_last)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ShiftRows: rotate each 32-bit row by r bytes.
  function automatic logic [127:0] model(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [31:0]  row;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      row = {s[127-8*r -: 8], s[95-8*r -: 8], s[63-8*r -: 8], s[31-8*r -: 8]};
      if (r != 0) begin
        if (!inv) row = (row << (8*r)) | (row >> (32-8*r));
        else      row = (row >> (8*r)) | (row << (32-8*r));
      end
      o[127-8*r -: 8] = row[31:24];
      o[95-8*r  -: 8] = row[23:16];
      o[63-8*r  -: 8] = row[15:8];
      o[31-8*r  -: 8] = row[7:0];
    end
    return o;
  endfunction

  task automatic push_cols(input logic [127:0] cols, input bit to_inv);
    beat_t b;
    for (int c = 0; c < 4; c++) begin
      b.last = (c == 3);
      b.col  = cols[127-32*c -: 32];
      if (to_inv) iq.push_back(b);
      else        q.push_back(b);
    end
  endtask

  task automatic expect_block(input logic [127:0] blk);
    push_cols(model(blk, 1'b0), 1'b0);
  endtask

  // Present one column: drive at the negedge, wait (bounded) for in_ready,
  // transfer on the posedge, then drop valid again at posedge+1.
  task automatic send_col(input logic [31:0] col, input int gap,
                          output int stalls);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_col   = col;
    stalls   = 0;
    while (!in_ready && stalls < 1000) begin
      @(negedge clk);
      stalls++;
    end
    if (!in_ready) begin
      check("send_timeout", 64'd1, 64'd0);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_block(input logic [127:0] blk, input int gapmax,
                            output int stalls_total);
    int s;
    int gap;
    stalls_total = 0;
    for (int c = 0; c < 4; c++) begin
      gap = 0;
      if (gapmax > 0 && $urandom_range(0, 2) == 0) gap = $urandom_range(1, gapmax);
      send_col(blk[127-32*c -: 32], gap, s);
      stalls_total += s;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || iq.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_q", 64'(q.size()), 64'd0);
  endtask

  // Forward monitor: pop on every output transfer; an idle output must read zero.
  always begin
    @(negedge clk);
    #1;
    if (out_valid && out_ready) begin
      out_cyc.push_back(cyc);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected none", {out_last, out_col});
      end else begin
        check("beat", 64'({out_last, out_col}), 64'(q.pop_front()));
      end
    end else if (!out_valid) begin
      check("idle_zero", 64'({out_last, out_col}), 64'd0);
    end
  end

  // Inverse-instance monitor.
  always begin
    @(negedge clk);
    #1;
    if (i_out_valid && i_out_ready) begin
      if (iq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL inv_unexpected_beat: got %h expected none", {i_out_last, i_out_col});
      end else begin
        check("inv_beat", 64'({i_out_last, i_out_col}), 64'(iq.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            s;
    logic [127:0]  blk_a, blk_b, blk_c;
    rst_n = 1'b0;
    in_valid = 1'b0; in_col = '0; out_ready = 1'b0;
    i_in_valid = 1'b0; i_in_col = '0; i_out_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    #2;
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_out_col",   64'(out_col),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2 check("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Test 1: FIPS-197 round-1 vector with the latency check.
    @(negedge clk);
    out_ready = 1'b1;
    push_cols(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0);
    blk_a = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    for (int c = 0; c < 4; c++) begin
      send_col(blk_a[127-32*c -: 32], 0, s);
      if (c == 2) check("partial_hidden", 64'(out_valid), 64'd0);
      if (c == 3) check("latency_valid",  64'(out_valid), 64'd1);
    end
    drain();

    // Test 2: inverse instance on the same vector.
    @(negedge clk);
    i_out_ready = 1'b1;
    push_cols(128'hd42711ae_e0bf98f1_b8b45de5_1e415230, 1'b1);
    blk_a = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      i_in_valid = 1'b1;
      i_in_col   = blk_a[127-32*c -: 32];
      check("inv_in_ready", 64'(i_in_ready), 64'd1);
      @(posedge clk);
      #1 i_in_valid = 1'b0;
    end
    drain();
    check("inv_drained", 64'(iq.size()), 64'd0);

    // Test 3: eight back-to-back blocks with no input stalls and no output gaps.
    begin
      int total = 0;
      for (int b = 0; b < 8; b++) begin
        blk_a = {$urandom, $urandom, $urandom, $urandom};
        expect_block(blk_a);
        send_block(blk_a, 0, s);
        total += s;
      end
      check("stream_stalls", 64'(total), 64'd0);
      drain();
      check("stream_no_gaps",
            64'(out_cyc[out_cyc.size()-1] - out_cyc[out_cyc.size()-32]), 64'd31);
    end

    // Test 4: backpressure with three blocks offered.
    @(negedge clk);
    out_ready = 1'b0;
    blk_a = {$urandom, $urandom, $urandom, $urandom};
    blk_b = {$urandom, $urandom, $urandom, $urandom};
    blk_c = {$urandom, $urandom, $urandom, $urandom};
    expect_block(blk_a);
    expect_block(blk_b);
    expect_block(blk_c);
    begin
      int total;
      send_block(blk_a, 0, s);
      total = s;
      send_block(blk_b, 0, s);
      total += s;
      check("bp_fill_stalls", 64'(total), 64'd0);
    end
    check("bp_full_in_ready", 64'(in_ready), 64'd0);
    fork
      send_block(blk_c, 0, s);
      begin
        repeat (3) begin
          @(negedge clk);
          #2;
          check("bp_in_ready", 64'(in_ready), 64'd0);
          check("bp_col",      64'(out_col),  64'(q[0].col));
          check("bp_last",     64'(out_last), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Test 5: random valid/ready toggling, 1000 blocks.
    rand_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 1000; b++) begin
          blk_a = {$urandom, $urandom, $urandom, $urandom};
          expect_block(blk_a);
          send_block(blk_a, 2, s);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(negedge clk);
    out_ready = 1'b1;
    drain();

    // Test 6: reset with one full bank and a partial block discards both.
    @(negedge clk);
    out_ready = 1'b0;
    blk_a = {$urandom, $urandom, $urandom, $urandom};
    send_block(blk_a, 0, s);
    send_col(32'h0a0a0a0a, 0, s);
    send_col(32'h0b0b0b0b, 0, s);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("mid_rst_in_ready",  64'(in_ready),  64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #2 check("post_rst_empty", 64'(out_valid), 64'd0);
    blk_b = {$urandom, $urandom, $urandom, $urandom};
    expect_block(blk_b);
    send_block(blk_b, 0, s);
    drain();
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
